// File: rtl/axi_byte_mem_slave_if.sv
// AXI4 bus bundle between a master and the byte-memory slave.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid never waits on ready, and payload holds steady while valid is high and ready is low.
interface axi_byte_mem_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp,
    output ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output w_valid, w_data, w_strb, w_last,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp,
    input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi_byte_mem_slave.sv
// AXI4 slave over a byte-wide memory: one INCR/FIXED burst of 8-bit beats at a time,
// AW/AR arbitrated round-robin, ID echoed on B and R, SLVERR for unsupported bursts.
module axi_byte_mem_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_byte_mem_slave_if.slave  axi,
  output logic [1:0]           state_dbg
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  state_t                state;
  logic                  rr_rd;
  logic [ID_WIDTH-1:0]   id_q;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  fixed_q;
  logic                  err;
  logic                  w_ready_q;
  logic                  b_valid_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             idle_ok;
  logic             aw_hs;
  logic             ar_hs;
  logic             w_hs;
  logic             last_beat;
  logic             aw_bad;
  logic             ar_bad;
  logic             mem_we;
  logic [IDX_W-1:0] next_idx;

  // Address readiness is gated by rst_n so nothing is accepted while reset is held.
  assign idle_ok      = rst_n && (state == IDLE);
  assign axi.aw_ready = idle_ok && axi.aw_valid && (!axi.ar_valid || !rr_rd);
  assign axi.ar_ready = idle_ok && axi.ar_valid && (!axi.aw_valid || rr_rd);
  assign aw_hs        = axi.aw_valid && axi.aw_ready;
  assign ar_hs        = axi.ar_valid && axi.ar_ready;
  assign w_hs         = axi.w_valid && w_ready_q;
  assign last_beat    = (beat_cnt == len_q);
  assign next_idx     = fixed_q ? idx : idx + 1'b1;
  assign aw_bad       = (axi.aw_size != 3'd0) || axi.aw_burst[1];
  assign ar_bad       = (axi.ar_size != 3'd0) || axi.ar_burst[1];
  assign mem_we       = (state == W_DATA) && w_hs && axi.w_strb[0] && !err;

  assign axi.w_ready  = w_ready_q;
  assign axi.b_valid  = b_valid_q;
  assign axi.b_id     = id_q;
  assign axi.b_resp   = (b_valid_q && err) ? 2'b10 : 2'b00;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_id     = id_q;
  assign axi.r_data   = (r_valid_q && !err) ? mem[idx] : '0;
  assign axi.r_resp   = (r_valid_q && err) ? 2'b10 : 2'b00;
  assign axi.r_last   = r_valid_q && last_beat;
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_rd     <= 1'b0;
      id_q      <= '0;
      idx       <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      fixed_q   <= 1'b0;
      err       <= 1'b0;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q      <= axi.aw_id;
            idx       <= axi.aw_addr[IDX_W-1:0];
            len_q     <= axi.aw_len;
            fixed_q   <= (axi.aw_burst == 2'b00);
            err       <= aw_bad;
            beat_cnt  <= '0;
            rr_rd     <= 1'b1;
            w_ready_q <= 1'b1;
            state     <= W_DATA;
          end else if (ar_hs) begin
            id_q      <= axi.ar_id;
            idx       <= axi.ar_addr[IDX_W-1:0];
            len_q     <= axi.ar_len;
            fixed_q   <= (axi.ar_burst == 2'b00);
            err       <= ar_bad;
            beat_cnt  <= '0;
            rr_rd     <= 1'b0;
            r_valid_q <= 1'b1;
            state     <= R_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // The beat count ends the burst; a misplaced WLAST only poisons the response.
            if (axi.w_last != last_beat) err <= 1'b1;
            if (last_beat) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              state     <= W_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              idx      <= next_idx;
            end
          end
        end
        W_RESP: begin
          if (axi.b_ready) begin
            b_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        R_DATA: begin
          if (axi.r_ready) begin
            if (last_beat) begin
              r_valid_q <= 1'b0;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              idx      <= next_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= axi.w_data;
  end
endmodule

// File: tb/tb_axi_byte_mem_slave.sv
// Bench for axi_byte_mem_slave: directed scenarios plus random bursts checked every cycle
// against a byte-array model with expected B/R queues.
module tb_axi_byte_mem_slave;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  axi_byte_mem_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) axi ();

  axi_byte_mem_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(4096)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi       (axi),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: byte array, which bytes hold known data, expected responses.
  logic [7:0]  model_mem   [4096];
  bit          model_known [4096];
  logic [15:0] r_exp_q[$];   // {check_data, last, resp[1:0], id[3:0], data[7:0]}
  logic [5:0]  b_exp_q[$];   // {id[3:0], resp[1:0]}
  bit          busy   = 1'b0;
  bit          fav_wr = 1'b1;
  int          acc_order[$]; // 0 = write accepted, 1 = read accepted

  logic [7:0]  wbuf    [256];
  bit          sbuf    [256];
  logic [7:0]  rx_data [256];
  logic        rx_last [256];
  logic [1:0]  last_bresp;
  logic [15:0] mon_e;
  bit          exp_aw;
  bit          exp_ar;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_quiet", {axi.aw_ready, axi.ar_ready, axi.w_ready, axi.b_valid, axi.r_valid}, 0);
      chk("rst_zero", {axi.b_id, axi.r_id, axi.r_data, axi.b_resp, axi.r_resp, axi.r_last}, 0);
      busy   = 1'b0;
      fav_wr = 1'b1;
      b_exp_q.delete();
      r_exp_q.delete();
    end else begin
      exp_aw = !busy && axi.aw_valid && (!axi.ar_valid || fav_wr);
      exp_ar = !busy && axi.ar_valid && (!axi.aw_valid || !fav_wr);
      chk("aw_ready", axi.aw_ready, exp_aw);
      chk("ar_ready", axi.ar_ready, exp_ar);
      if (!busy) chk("w_ready_idle", axi.w_ready, 0);
      if (axi.b_valid) begin
        if (b_exp_q.size() == 0) chk("b_unexpected", axi.b_valid, 0);
        else chk("b_fields", {axi.b_id, axi.b_resp}, b_exp_q[0]);
      end
      if (axi.r_valid) begin
        if (r_exp_q.size() == 0) chk("r_unexpected", axi.r_valid, 0);
        else begin
          mon_e = r_exp_q[0];
          chk("r_ctl", {axi.r_id, axi.r_resp, axi.r_last}, {mon_e[11:8], mon_e[13:12], mon_e[14]});
          if (mon_e[15]) chk("r_data", axi.r_data, mon_e[7:0]);
        end
      end
      if (axi.aw_valid && axi.aw_ready) begin busy = 1'b1; fav_wr = 1'b0; acc_order.push_back(0); end
      if (axi.ar_valid && axi.ar_ready) begin busy = 1'b1; fav_wr = 1'b1; acc_order.push_back(1); end
      if (axi.b_valid && axi.b_ready) begin
        if (b_exp_q.size() > 0) void'(b_exp_q.pop_front());
        busy = 1'b0;
      end
      if (axi.r_valid && axi.r_ready && r_exp_q.size() > 0) begin
        mon_e = r_exp_q.pop_front();
        if (mon_e[14]) busy = 1'b0;
      end
    end
  end

  // which: 0 = aw_ready, 1 = w_ready, 2 = ar_ready. Returns at the negedge before the handshake.
  task automatic wait_hs(input int which, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if ((which == 0 && axi.aw_ready) || (which == 1 && axi.w_ready) ||
          (which == 2 && axi.ar_ready)) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic write_txn(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int early,
                           input int bdelay, input bit gaps);
    bit ok;
    bit e;
    logic [11:0] ix;
    axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
    axi.aw_size = size; axi.aw_burst = burst; axi.aw_valid = 1'b1;
    wait_hs(0, ok);
    if (!ok) begin chk("aw_accept", 0, 1); axi.aw_valid = 1'b0; return; end
    e  = (size != 3'd0) || burst[1];
    ix = addr[11:0];
    for (int i = 0; i <= int'(len); i++) begin
      if (sbuf[i] && !e) begin model_mem[ix] = wbuf[i]; model_known[ix] = 1'b1; end
      if (((early >= 0) ? (i == early) : (i == int'(len))) != (i == int'(len))) e = 1'b1;
      if (burst == 2'b01) ix = ix + 12'd1;
    end
    b_exp_q.push_back({id, e ? 2'b10 : 2'b00});
    cycle();
    axi.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin axi.w_valid = 1'b0; cycle(); end
      axi.w_valid = 1'b1;
      axi.w_data  = wbuf[i];
      axi.w_strb  = sbuf[i];
      axi.w_last  = (early >= 0) ? (i == early) : (i == int'(len));
      wait_hs(1, ok);
      if (!ok) begin chk("w_accept", 0, 1); axi.w_valid = 1'b0; return; end
      cycle();
    end
    axi.w_valid = 1'b0;
    axi.w_last  = 1'b0;
    axi.b_ready = (bdelay == 0);
    @(negedge clk);
    chk("b_latency", axi.b_valid, 1);
    for (int d = 1; d <= bdelay; d++) begin
      cycle();
      if (d == bdelay) axi.b_ready = 1'b1;
      @(negedge clk);
      chk("b_hold", axi.b_valid, 1);
    end
    last_bresp = axi.b_resp;
    cycle();
    axi.b_ready = 1'b0;
  endtask

  // rmode: 0 = always ready, 1 = toggle every cycle, 2 = random.
  task automatic read_txn(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rmode);
    bit ok;
    bit e;
    int got;
    logic [11:0] ix;
    axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
    axi.ar_size = size; axi.ar_burst = burst; axi.ar_valid = 1'b1;
    wait_hs(2, ok);
    if (!ok) begin chk("ar_accept", 0, 1); axi.ar_valid = 1'b0; return; end
    e  = (size != 3'd0) || burst[1];
    ix = addr[11:0];
    for (int i = 0; i <= int'(len); i++) begin
      r_exp_q.push_back({e || model_known[ix], i == int'(len), e ? 2'b10 : 2'b00, id,
                         e ? 8'h00 : model_mem[ix]});
      if (burst == 2'b01) ix = ix + 12'd1;
    end
    cycle();
    axi.ar_valid = 1'b0;
    axi.r_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    got = 0;
    @(negedge clk);
    chk("r_latency", axi.r_valid, 1);
    for (int g = 0; g < 1200 && got <= int'(len); g++) begin
      if (axi.r_valid && axi.r_ready) begin
        rx_data[got] = axi.r_data;
        rx_last[got] = axi.r_last;
        got++;
      end
      cycle();
      if (rmode == 1) axi.r_ready = ~axi.r_ready;
      else if (rmode == 2) axi.r_ready = 1'($urandom_range(0, 1));
      if (got <= int'(len)) @(negedge clk);
    end
    axi.r_ready = 1'b0;
    chk("r_beats", got, int'(len) + 1);
  endtask

  task automatic fill(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] d3);
    wbuf[0] = d0; wbuf[1] = d1; wbuf[2] = d2; wbuf[3] = d3;
    for (int i = 0; i < 256; i++) sbuf[i] = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [15:0] a;
    logic [7:0]  ln;
    logic [1:0]  bu;
    logic [2:0]  sz;
    int          early;
    axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0;
    axi.r_ready = 0;
    for (int i = 0; i < 4096; i++) model_known[i] = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out", {axi.w_ready, axi.b_valid, axi.r_valid, axi.b_resp, axi.r_last}, 0);
    cycle();

    // T3: simultaneous AW and AR from reset alternate WR, RD, WR.
    fill(8'h5A, 8'h00, 8'h00, 8'h00);
    axi.ar_id = 4'd7; axi.ar_addr = 16'h0300; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 2'b01;
    axi.ar_valid = 1'b1;
    write_txn(4'd1, 16'h0300, 8'd0, 3'd0, 2'b01, -1, 0, 0);
    axi.aw_valid = 1'b1;
    read_txn(4'd7, 16'h0300, 8'd0, 3'd0, 2'b01, 0);
    chk("t3_rdata", rx_data[0], 8'h5A);
    fill(8'h6B, 8'h00, 8'h00, 8'h00);
    write_txn(4'd3, 16'h0301, 8'd0, 3'd0, 2'b01, -1, 0, 0);
    if (acc_order.size() < 3) chk("t3_order_count", acc_order.size(), 3);
    else chk("t3_order", {acc_order[0][0], acc_order[1][0], acc_order[2][0]}, 3'b010);

    // T1: write then read back.
    fill(8'h11, 8'h22, 8'h33, 8'h44);
    write_txn(4'd2, 16'h1004, 8'd3, 3'd0, 2'b01, -1, 0, 0);
    chk("t1_bresp", last_bresp, 2'b00);
    read_txn(4'd2, 16'h1004, 8'd3, 3'd0, 2'b01, 0);
    chk("t1_rdata", {rx_data[0], rx_data[1], rx_data[2], rx_data[3]}, 32'h11223344);
    chk("t1_rlast", {rx_last[0], rx_last[1], rx_last[2], rx_last[3]}, 4'b0001);

    // T2: index wrap and FIXED bursts.
    fill(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    write_txn(4'd4, 16'h0FFE, 8'd3, 3'd0, 2'b01, -1, 0, 0);
    read_txn(4'd4, 16'h0000, 8'd1, 3'd0, 2'b01, 0);
    chk("t2_wrap", {rx_data[0], rx_data[1]}, 16'hA2A3);
    read_txn(4'd4, 16'h0FFE, 8'd1, 3'd0, 2'b01, 2);
    chk("t2_wrap_hi", {rx_data[0], rx_data[1]}, 16'hA0A1);
    fill(8'h01, 8'h02, 8'h03, 8'h04);
    write_txn(4'd5, 16'h0010, 8'd3, 3'd0, 2'b00, -1, 0, 0);
    chk("model_fixed", model_mem[16], 8'h04);
    read_txn(4'd5, 16'h0010, 8'd0, 3'd0, 2'b01, 0);
    chk("t2_fixed", rx_data[0], 8'h04);

    // T4: B and R backpressure.
    fill(8'hC1, 8'hC2, 8'hC3, 8'h00);
    write_txn(4'd6, 16'h0400, 8'd2, 3'd0, 2'b01, -1, 5, 0);
    read_txn(4'd6, 16'h0400, 8'd2, 3'd0, 2'b01, 1);
    chk("t4_rdata", {rx_data[0], rx_data[1], rx_data[2]}, 24'hC1C2C3);

    // T5: error responses.
    fill(8'h99, 8'h98, 8'h97, 8'h96);
    write_txn(4'd8, 16'h1004, 8'd3, 3'd1, 2'b01, -1, 0, 0);
    chk("t5_size_bresp", last_bresp, 2'b10);
    read_txn(4'd8, 16'h1004, 8'd3, 3'd0, 2'b01, 0);
    chk("t5_unchanged", {rx_data[0], rx_data[1], rx_data[2], rx_data[3]}, 32'h11223344);
    fill(8'hD0, 8'hD1, 8'hD2, 8'hD3);
    write_txn(4'd9, 16'h0500, 8'd3, 3'd0, 2'b01, 1, 0, 0);
    chk("t5_wlast_bresp", last_bresp, 2'b10);
    read_txn(4'd10, 16'h1004, 8'd3, 3'd0, 2'b10, 0);
    chk("t5_wrap_rdata", {rx_data[0], rx_data[1], rx_data[2], rx_data[3]}, 32'h0);

    // T6: reset in the middle of a write burst.
    fill(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    axi.aw_id = 4'd5; axi.aw_addr = 16'h0200; axi.aw_len = 8'd3; axi.aw_size = 0; axi.aw_burst = 2'b01;
    axi.aw_valid = 1'b1;
    wait_hs(0, ok);
    if (!ok) chk("t6_aw_accept", 0, 1);
    cycle();
    axi.aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi.w_valid = 1'b1; axi.w_data = wbuf[i]; axi.w_strb = 1'b1; axi.w_last = 1'b0;
      wait_hs(1, ok);
      if (!ok) chk("t6_w_accept", 0, 1);
      model_mem[12'h200 + 12'(i)] = wbuf[i];
      model_known[12'h200 + 12'(i)] = 1'b1;
      cycle();
    end
    axi.w_valid = 1'b1; axi.w_data = wbuf[2];
    rst_n = 1'b0;
    axi.w_valid = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    read_txn(4'd11, 16'h0200, 8'd1, 3'd0, 2'b01, 0);
    chk("t6_kept", {rx_data[0], rx_data[1]}, 16'hE1E2);
    fill(8'hF0, 8'h00, 8'h00, 8'h00);
    write_txn(4'd12, 16'h0202, 8'd0, 3'd0, 2'b01, -1, 0, 0);
    chk("t6_new_bresp", last_bresp, 2'b00);

    // Random phase over a preloaded window.
    for (int i = 0; i < 256; i++) begin wbuf[i] = 8'($urandom); sbuf[i] = 1'b1; end
    write_txn(4'd0, 16'h0F00, 8'd255, 3'd0, 2'b01, -1, 1, 0);
    for (int n = 0; n < 40; n++) begin
      a[15:12] = 4'($urandom_range(0, 15));
      a[11:0]  = 12'(12'hF00 + $urandom_range(0, 255));
      ln = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 7));
      sz = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
      bu = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 256; i++) begin
          wbuf[i] = 8'($urandom);
          sbuf[i] = ($urandom_range(0, 9) != 0);
        end
        early = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
        write_txn(4'($urandom), a, ln, sz, bu, early, int'($urandom_range(0, 3)), 1);
      end else begin
        read_txn(4'($urandom), a, ln, sz, bu, int'($urandom_range(0, 2)));
      end
    end
    repeat (3) cycle();
    chk("end_b_queue", b_exp_q.size(), 0);
    chk("end_r_queue", r_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
